memory_access_unit: RTL and testbench

Consumer end of the memory-buffer issue interface. Accepts one memory op at a time (oldest load/store selected upstream), reads its operand registers from the physical register file, performs a single-word data-memory transaction over a req/ack handshake, then reports completion to the ROB. For loads it also writes the result back to the destination physical register.

---
 rtl/memory_access_unit.sv | 176 +++++++++++++++++
 tb/tb_memory_access_unit.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_unit.sv
// memory_access_unit: executes one load/store at a time against a single-word
// req/ack data memory, then reports completion to the ROB and, for loads,
// writes the result back to the physical register file.

`ifndef ROB_LENGTH
`define ROB_LENGTH 16
`endif
`ifndef NUM_D_REG
`define NUM_D_REG 32
`endif

package mau_pkg;
  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } MemOp;
endpackage

module memory_access_unit
  import mau_pkg::*;
#(
  parameter int ROB_AW = $clog2(`ROB_LENGTH),
  parameter int PR_AW  = $clog2(`NUM_D_REG),
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  // issue interface
  input  logic              in_valid,
  input  logic [ROB_AW-1:0] in_rob_addr,
  input  MemOp              in_mem_op,
  input  logic [PR_AW-1:0]  in_raw_addr,
  input  logic [PR_AW-1:0]  in_rt_addr,
  output logic              in_ready,
  // register file read ports
  output logic [PR_AW-1:0]  rf_ra_addr,
  output logic [PR_AW-1:0]  rf_rb_addr,
  input  logic [DATA_W-1:0] rf_ra_data,
  input  logic [DATA_W-1:0] rf_rb_data,
  // data memory
  output logic              dm_req,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] dm_rdata,
  // squash
  input  logic              flush,
  // write-back and completion
  output logic              wb_valid,
  output logic [PR_AW-1:0]  wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              done_valid,
  output logic [ROB_AW-1:0] done_rob_addr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state;
  logic                kill;
  MemOp                op_q;
  logic [PR_AW-1:0]    dest_q;
  logic [ROB_AW-1:0]   rob_q;

  logic                dm_req_q;
  logic                dm_we_q;
  logic [DATA_W-1:0]   dm_addr_q;
  logic [DATA_W-1:0]   dm_wdata_q;
  logic                wb_q;
  logic [PR_AW-1:0]    wb_reg_q;
  logic [DATA_W-1:0]   wb_data_q;
  logic                done_q;
  logic [ROB_AW-1:0]   done_rob_q;

  logic                accept;

  // Acceptance is possible whenever the unit is idle or finishing; flush blocks it.
  always_comb begin
    in_ready = ((state == IDLE) || (state == RESP)) && !flush;
    accept   = in_valid && in_ready;
  end

  // Register-file read indices: the address register differs between loads and stores.
  always_comb begin
    rf_ra_addr = (in_mem_op == MEM_READ) ? in_rt_addr : in_raw_addr;
    rf_rb_addr = in_rt_addr;
  end

  // Memory-side and result outputs; RESP strobes are squashed by a same-cycle flush.
  always_comb begin
    dm_req        = dm_req_q;
    dm_we         = dm_we_q;
    dm_addr       = dm_addr_q;
    dm_wdata      = dm_wdata_q;
    wb_valid      = wb_q && !flush;
    wb_reg        = wb_reg_q;
    wb_data       = wb_data_q;
    done_valid    = done_q && !flush;
    done_rob_addr = done_rob_q;
  end

  // Control FSM with registered request and completion outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      kill       <= 1'b0;
      op_q       <= MEM_READ;
      dest_q     <= '0;
      rob_q      <= '0;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      wb_q       <= 1'b0;
      wb_reg_q   <= '0;
      wb_data_q  <= '0;
      done_q     <= 1'b0;
      done_rob_q <= '0;
    end else begin
      case (state)
        IDLE, RESP: begin
          // completion strobes last exactly one cycle
          done_q <= 1'b0;
          wb_q   <= 1'b0;
          if (accept) begin
            state     <= ACCESS;
            rob_q     <= in_rob_addr;
            op_q      <= in_mem_op;
            dest_q    <= in_raw_addr;
            dm_req_q  <= 1'b1;
            dm_we_q   <= (in_mem_op == MEM_WRITE);
            dm_addr_q <= rf_ra_data;
            if (in_mem_op == MEM_WRITE) begin
              dm_wdata_q <= rf_rb_data;
            end
          end else begin
            state <= IDLE;
          end
        end

        ACCESS: begin
          if (dm_ack) begin
            dm_req_q <= 1'b0;
            dm_we_q  <= 1'b0;
            kill     <= 1'b0;
            // a flush arriving with the ack counts as a kill too
            if (kill || flush) begin
              state <= IDLE;
            end else begin
              state      <= RESP;
              done_q     <= 1'b1;
              done_rob_q <= rob_q;
              if (op_q == MEM_READ) begin
                wb_q      <= 1'b1;
                wb_reg_q  <= dest_q;
                wb_data_q <= dm_rdata;
              end
            end
          end else if (flush) begin
            // the request stays up until acked; only the completion is dropped
            kill <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_unit.sv
// Bench for memory_access_unit: register-file and memory models, a completion
// scoreboard, and directed cycle checks around flush and reset.

module tb_memory_access_unit;
  import mau_pkg::*;

  localparam int ROB_AW = 4;
  localparam int PR_AW  = 5;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              in_valid;
  logic [ROB_AW-1:0] in_rob_addr;
  MemOp              in_mem_op;
  logic [PR_AW-1:0]  in_raw_addr;
  logic [PR_AW-1:0]  in_rt_addr;
  logic              in_ready;
  logic [PR_AW-1:0]  rf_ra_addr;
  logic [PR_AW-1:0]  rf_rb_addr;
  logic [DATA_W-1:0] rf_ra_data;
  logic [DATA_W-1:0] rf_rb_data;
  logic              dm_req;
  logic              dm_we;
  logic [DATA_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;
  logic              flush;
  logic              wb_valid;
  logic [PR_AW-1:0]  wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic              done_valid;
  logic [ROB_AW-1:0] done_rob_addr;

  memory_access_unit #(
    .ROB_AW (ROB_AW),
    .PR_AW  (PR_AW),
    .DATA_W (DATA_W)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .in_valid      (in_valid),
    .in_rob_addr   (in_rob_addr),
    .in_mem_op     (in_mem_op),
    .in_raw_addr   (in_raw_addr),
    .in_rt_addr    (in_rt_addr),
    .in_ready      (in_ready),
    .rf_ra_addr    (rf_ra_addr),
    .rf_rb_addr    (rf_rb_addr),
    .rf_ra_data    (rf_ra_data),
    .rf_rb_data    (rf_rb_data),
    .dm_req        (dm_req),
    .dm_we         (dm_we),
    .dm_addr       (dm_addr),
    .dm_wdata      (dm_wdata),
    .dm_ack        (dm_ack),
    .dm_rdata      (dm_rdata),
    .flush         (flush),
    .wb_valid      (wb_valid),
    .wb_reg        (wb_reg),
    .wb_data       (wb_data),
    .done_valid    (done_valid),
    .done_rob_addr (done_rob_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // register file model
  logic [DATA_W-1:0] regs [32];
  assign rf_ra_data = regs[rf_ra_addr];
  assign rf_rb_data = regs[rf_rb_addr];

  // memory model: acks after ack_wait extra cycles of a held request
  logic [DATA_W-1:0] mem [256];
  int ack_wait = 0;
  int req_cnt  = 0;
  always @(negedge clk) begin
    if (!n_rst || !dm_req) begin
      dm_ack  = 1'b0;
      req_cnt = 0;
    end else if (req_cnt == ack_wait) begin
      dm_ack   = 1'b1;
      dm_rdata = mem[dm_addr];
      if (dm_we) mem[dm_addr] = dm_wdata;
      req_cnt  = 0;
    end else begin
      dm_ack  = 1'b0;
      req_cnt = req_cnt + 1;
    end
  end

  // scoreboard of expected completions
  typedef struct {
    logic [ROB_AW-1:0] rob;
    logic              is_load;
    logic [PR_AW-1:0]  dst;
    logic [DATA_W-1:0] data;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    if (wb_valid && !done_valid) check("wb_without_done", 32'd1, 32'd0);
    if (done_valid) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_done_rob", done_rob_addr, e.rob);
        check("sb_wb_valid", wb_valid, e.is_load);
        if (e.is_load) begin
          check("sb_wb_reg", wb_reg, e.dst);
          check("sb_wb_data", wb_data, e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input MemOp op, input logic [ROB_AW-1:0] rob,
                       input logic [PR_AW-1:0] raw, input logic [PR_AW-1:0] rt);
    in_valid    = 1'b1;
    in_mem_op   = op;
    in_rob_addr = rob;
    in_raw_addr = raw;
    in_rt_addr  = rt;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done_valid) begin
        seen = 1;
        break;
      end
    end
    check(tag, seen, 1'b1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_dm_req"}, dm_req, 1'b0);
    check({tag, "_dm_we"}, dm_we, 1'b0);
    check({tag, "_dm_addr"}, dm_addr, '0);
    check({tag, "_dm_wdata"}, dm_wdata, '0);
    check({tag, "_wb_valid"}, wb_valid, 1'b0);
    check({tag, "_wb_reg"}, wb_reg, '0);
    check({tag, "_wb_data"}, wb_data, '0);
    check({tag, "_done_valid"}, done_valid, 1'b0);
    check({tag, "_done_rob"}, done_rob_addr, '0);
  endtask

  initial begin
    int cnt;
    n_rst       = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_mem_op   = MEM_READ;
    in_rob_addr = '0;
    in_raw_addr = '0;
    in_rt_addr  = '0;
    dm_ack      = 1'b0;
    dm_rdata    = '0;
    for (int i = 0; i < 32; i++) regs[i] = 8'(i * 3);
    for (int i = 0; i < 256; i++) mem[i] = 8'(255 - i);
    regs[2] = 8'h10; regs[3] = 8'h40; regs[4] = 8'hC3; regs[5] = 8'h41;
    mem[8'h40] = 8'h5A; mem[8'h41] = 8'h77;

    #1;
    check_reset("rst");
    @(posedge clk); @(posedge clk); #1;
    n_rst = 1'b1;

    // load, zero wait
    ack_wait = 0;
    sb.push_back('{rob: 4'd5, is_load: 1'b1, dst: 5'd7, data: 8'h5A});
    drive(MEM_READ, 4'd5, 5'd7, 5'd3);
    @(negedge clk);
    check("ld_ready", in_ready, 1'b1);
    check("ld_ra_addr", rf_ra_addr, 5'd3);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("ld_req", dm_req, 1'b1);
    check("ld_we", dm_we, 1'b0);
    check("ld_addr", dm_addr, 8'h40);
    check("ld_busy", in_ready, 1'b0);
    @(negedge clk);
    check("ld_done", done_valid, 1'b1);
    @(negedge clk);
    check("ld_done_one_cycle", done_valid, 1'b0);

    // store, three wait cycles
    ack_wait = 3;
    step();
    sb.push_back('{rob: 4'd1, is_load: 1'b0, dst: '0, data: '0});
    drive(MEM_WRITE, 4'd1, 5'd2, 5'd4);
    step();
    in_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!dm_req) break;
      cnt++;
      check("st_addr", dm_addr, 8'h10);
      check("st_wdata", dm_wdata, 8'hC3);
      check("st_we", dm_we, 1'b1);
    end
    check("st_req_cycles", cnt, 4);
    check("st_done", done_valid, 1'b1);
    check("st_mem", mem[8'h10], 8'hC3);

    // back-to-back: second op accepted during RESP of the first
    ack_wait = 0;
    step();
    sb.push_back('{rob: 4'd2, is_load: 1'b1, dst: 5'd8, data: 8'h5A});
    sb.push_back('{rob: 4'd3, is_load: 1'b1, dst: 5'd9, data: 8'h77});
    drive(MEM_READ, 4'd2, 5'd8, 5'd3);
    step();
    drive(MEM_READ, 4'd3, 5'd9, 5'd5);
    @(negedge clk);
    check("b2b_busy", in_ready, 1'b0);
    check("b2b_req_a", dm_req, 1'b1);
    step();
    @(negedge clk);
    check("b2b_resp_ready", in_ready, 1'b1);
    check("b2b_done_a", done_valid, 1'b1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_req_b", dm_req, 1'b1);
    check("b2b_addr_b", dm_addr, 8'h41);
    @(negedge clk);
    check("b2b_done_b", done_valid, 1'b1);

    // flush while a load waits for its ack
    ack_wait = 2;
    step();
    drive(MEM_READ, 4'd4, 5'd10, 5'd3);
    step();
    in_valid = 1'b0;
    flush = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!dm_req) break;
      cnt++;
      if (i == 0) begin
        step();
        flush = 1'b0;
      end
    end
    check("kill_req_cycles", cnt, 3);
    check("kill_no_done", done_valid, 1'b0);
    check("kill_no_wb", wb_valid, 1'b0);
    check("kill_idle_ready", in_ready, 1'b1);
    regs[4] = 8'h99;
    step();
    sb.push_back('{rob: 4'd6, is_load: 1'b0, dst: '0, data: '0});
    drive(MEM_WRITE, 4'd6, 5'd2, 5'd4);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("post_kill_req", dm_req, 1'b1);
    check("post_kill_wdata", dm_wdata, 8'h99);
    wait_done("post_kill_done");

    // flush in the same cycle as the ack
    ack_wait = 0;
    step();
    drive(MEM_READ, 4'd12, 5'd13, 5'd3);
    step();
    in_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    check("fa_req", dm_req, 1'b1);
    step();
    flush = 1'b0;
    @(negedge clk);
    check("fa_req_drop", dm_req, 1'b0);
    check("fa_no_done", done_valid, 1'b0);
    check("fa_ready", in_ready, 1'b1);

    // flush coincident with RESP and a pending op
    step();
    sb.push_back('{rob: 4'd8, is_load: 1'b1, dst: 5'd12, data: 8'h77});
    drive(MEM_READ, 4'd7, 5'd11, 5'd3);
    step();
    in_valid = 1'b0;
    step();
    flush = 1'b1;
    drive(MEM_READ, 4'd8, 5'd12, 5'd5);
    @(negedge clk);
    check("fr_no_done", done_valid, 1'b0);
    check("fr_no_wb", wb_valid, 1'b0);
    check("fr_not_ready", in_ready, 1'b0);
    step();
    flush = 1'b0;
    @(negedge clk);
    check("fr_not_accepted", dm_req, 1'b0);
    check("fr_ready_again", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("fr_req_b", dm_req, 1'b1);
    wait_done("fr_done_b");

    // reset in the middle of an access
    ack_wait = 1000;
    step();
    drive(MEM_WRITE, 4'd9, 5'd2, 5'd4);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("mr_req", dm_req, 1'b1);
    #2;
    n_rst = 1'b0;
    #1;
    check_reset("mr");
    step();
    n_rst = 1'b1;
    @(negedge clk);
    check("mr_ready_after", in_ready, 1'b1);
    check("mr_req_after", dm_req, 1'b0);

    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
